// File: rtl/seq_shifter_n_bit_pkg.sv
// Shared mode encodings and FSM state type for the sequential shifter.
package shifter_pkg;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_shifter_n_bit_if.sv
// Request/response bundle between the ALU control and the sequential shifter.
interface seq_shifter_n_bit_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 4
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] in_a;
    logic [SHW-1:0]   shift;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, in_a, shift,
        input  out, cout, busy, done
    );

    modport slave (
        input  start, mode, in_a, shift,
        output out, cout, busy, done
    );
endinterface

// File: rtl/seq_shifter_n_bit_shift_step.sv
// Combinational single-step shifter: moves data by k (1..STEP) positions.
module shift_step
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1,
    parameter int unsigned KW    = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [KW-1:0]    k_i,
    input  logic [1:0]       mode_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o,
    output logic             bit_o
);
    localparam int unsigned WW = $clog2(WIDTH + 1);

    logic [WW-1:0]    rk;
    logic [WIDTH-1:0] wrapped;
    logic             lo_bit;
    logic [WIDTH-1:0] fill_mask;

    // Select the shifted word and the last bit to leave it for this step
    always_comb begin
        rk        = WW'(WIDTH) - WW'(k_i);
        // Top k bits moved down to the LSB end; wrapped[0] is data_i[WIDTH-k]
        wrapped   = data_i >> rk;
        lo_bit    = |(data_i & (WIDTH'(1) << (k_i - KW'(1))));
        fill_mask = ~({WIDTH{1'b1}} >> k_i);
        data_o    = data_i;
        bit_o     = 1'b0;
        case (mode_i)
            MODE_LSL: begin
                data_o = data_i << k_i;
                bit_o  = wrapped[0];
            end
            MODE_LSR: begin
                data_o = data_i >> k_i;
                bit_o  = lo_bit;
            end
            MODE_ASR: begin
                data_o = (data_i >> k_i) | (fill_i ? fill_mask : '0);
                bit_o  = lo_bit;
            end
            MODE_ROL: begin
                data_o = (data_i << k_i) | wrapped;
                bit_o  = wrapped[0];
            end
            default: begin
                data_o = data_i;
                bit_o  = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/seq_shifter_n_bit.sv
// Multi-cycle LSL/LSR/ASR/ROL shifter, up to STEP positions per clock.
module seq_shifter_n_bit
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 4,
    parameter int unsigned STEP  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_shifter_n_bit_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned KW = $clog2(STEP + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;
    logic             sign_q, sign_d;
    logic             cout_q, cout_d;
    // Set when LSL/LSR shift past WIDTH: the carry must stay 0
    logic             cout_hold_q, cout_hold_d;

    logic [KW-1:0]    k;
    logic [WIDTH-1:0] step_data;
    logic             step_bit;
    int unsigned      sh_i;
    int unsigned      n_i;

    // Positions applied this clock: min(remaining, STEP)
    always_comb begin
        if (rem_q > CW'(STEP)) begin
            k = KW'(STEP);
        end else begin
            k = KW'(rem_q);
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .data_i (work_q),
        .k_i    (k),
        .mode_i (mode_q),
        .fill_i (sign_q),
        .data_o (step_data),
        .bit_o  (step_bit)
    );

    // Next-state: accept in IDLE/DONE, step in RUN
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        rem_d       = rem_q;
        mode_d      = mode_q;
        sign_d      = sign_q;
        cout_d      = cout_q;
        cout_hold_d = cout_hold_q;
        sh_i        = 32'(bus.shift);
        if (bus.mode == MODE_ROL) begin
            n_i = sh_i % WIDTH;
        end else begin
            n_i = (sh_i > WIDTH) ? WIDTH : sh_i;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    work_d      = bus.in_a;
                    mode_d      = bus.mode;
                    sign_d      = bus.in_a[WIDTH-1];
                    cout_d      = 1'b0;
                    rem_d       = CW'(n_i);
                    cout_hold_d = (sh_i > WIDTH) &&
                                  (bus.mode == MODE_LSL || bus.mode == MODE_LSR);
                    state_d     = (n_i == 0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                work_d = step_data;
                rem_d  = rem_q - CW'(k);
                if (!cout_hold_q) begin
                    cout_d = step_bit;
                end
                // The last step lands us in DONE so done follows it directly
                if (rem_q <= CW'(STEP)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            rem_q       <= '0;
            mode_q      <= MODE_LSL;
            sign_q      <= 1'b0;
            cout_q      <= 1'b0;
            cout_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            mode_q      <= mode_d;
            sign_q      <= sign_d;
            cout_q      <= cout_d;
            cout_hold_q <= cout_hold_d;
        end
    end

    assign bus.out  = work_q;
    assign bus.cout = cout_q;
    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
endmodule

// File: tb/tb_seq_shifter_n_bit.sv
// Scoreboard bench: two shifters (STEP=1 and STEP=4) against an arithmetic model.
module tb_seq_shifter_n_bit;
    localparam int W  = 8;
    localparam int SA = 1;
    localparam int SB = 4;

    typedef struct {
        int o;
        int c;
        int lat;
        int t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_a_out = 0;
    exp_t qa[$];
    exp_t qb[$];

    seq_shifter_n_bit_if #(.WIDTH(W), .SHW(4)) bus_a ();
    seq_shifter_n_bit_if #(.WIDTH(W), .SHW(4)) bus_b ();

    seq_shifter_n_bit #(.WIDTH(W), .SHW(4), .STEP(SA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    seq_shifter_n_bit #(.WIDTH(W), .SHW(4), .STEP(SB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operand value
    function automatic void model(input int m, input int a, input int sh,
                                  output int o, output int c, output int n);
        int s;
        int mask;
        mask = (1 << W) - 1;
        n = (sh > W) ? W : sh;
        case (m)
            0: begin
                o = (a << sh) & mask;
                c = (sh == 0 || sh > W) ? 0 : ((a >> (W - sh)) & 1);
            end
            1: begin
                o = a >> sh;
                c = (sh == 0 || sh > W) ? 0 : ((a >> (sh - 1)) & 1);
            end
            2: begin
                s = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
                o = (s >>> sh) & mask;
                if (sh == 0) c = 0;
                else if (sh > W) c = (a >> (W - 1)) & 1;
                else c = (a >> (sh - 1)) & 1;
            end
            default: begin
                n = sh % W;
                o = ((a << n) | (a >> (W - n))) & mask;
                c = (n == 0) ? 0 : (o & 1);
            end
        endcase
    endfunction

    function automatic exp_t make_exp(input int m, input int a, input int sh,
                                      input int step, input int t0);
        exp_t e;
        int n;
        model(m, a, sh, e.o, e.c, n);
        e.lat = 1 + (n + step - 1) / step;
        e.t0  = t0;
        return e;
    endfunction

    // Monitors: pop an expectation on every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_a.done) begin
            if (qa.size() == 0) begin
                check("a_unexpected_done", 1, 0);
            end else begin
                e = qa.pop_front();
                check("a_out", int'(bus_a.out), e.o);
                check("a_cout", int'(bus_a.cout), e.c);
                check("a_latency", cyc - e.t0 + 1, e.lat);
                last_a_out = e.o;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_b.done) begin
            if (qb.size() == 0) begin
                check("b_unexpected_done", 1, 0);
            end else begin
                e = qb.pop_front();
                check("b_out", int'(bus_b.out), e.o);
                check("b_cout", int'(bus_b.cout), e.c);
                check("b_latency", cyc - e.t0 + 1, e.lat);
            end
        end
    end

    // Issue one operation to both DUTs on the same edge; called at a negedge
    task automatic issue2(input int m, input int a, input int sh);
        int g = 0;
        while ((bus_a.busy || bus_b.busy) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("idle_wait_timeout", g, 0);
        bus_a.start = 1'b1;
        bus_b.start = 1'b1;
        bus_a.mode  = 2'(m);
        bus_b.mode  = 2'(m);
        bus_a.in_a  = 8'(a);
        bus_b.in_a  = 8'(a);
        bus_a.shift = 4'(sh);
        bus_b.shift = 4'(sh);
        qa.push_back(make_exp(m, a, sh, SA, cyc + 1));
        qb.push_back(make_exp(m, a, sh, SB, cyc + 1));
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        // Scramble inputs after accept; the DUT must not re-sample them
        bus_a.in_a  = 8'($urandom_range(0, 255));
        bus_b.in_a  = 8'($urandom_range(0, 255));
        bus_a.mode  = 2'($urandom_range(0, 3));
        bus_b.mode  = 2'($urandom_range(0, 3));
        bus_a.shift = 4'($urandom_range(0, 15));
        bus_b.shift = 4'($urandom_range(0, 15));
    endtask

    task automatic issue_rand2();
        issue2(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 15)));
    endtask

    // start held high on DUT A; each op is accepted in the preceding DONE cycle
    task automatic b2b_a(input int nops);
        int m;
        int a;
        int sh;
        bus_a.start = 1'b1;
        for (int i = 0; i < nops; i++) begin
            int g = 0;
            while (bus_a.busy && g < 200) begin
                @(negedge clk);
                g++;
            end
            if (g >= 200) check("b2b_wait_timeout", g, 0);
            m  = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 255));
            sh = int'($urandom_range(0, 15));
            bus_a.mode  = 2'(m);
            bus_a.in_a  = 8'(a);
            bus_a.shift = 4'(sh);
            qa.push_back(make_exp(m, a, sh, SA, cyc + 1));
            @(negedge clk);
        end
        bus_a.start = 1'b0;
    endtask

    initial begin
        int g;
        bus_a.start = 1'b0; bus_a.mode = 2'd0; bus_a.in_a = 8'd0; bus_a.shift = 4'd0;
        bus_b.start = 1'b0; bus_b.mode = 2'd0; bus_b.in_a = 8'd0; bus_b.shift = 4'd0;
        repeat (2) @(negedge clk);
        check("reset_out", int'(bus_a.out), 0);
        check("reset_cout", int'(bus_a.cout), 0);
        check("reset_busy", int'(bus_a.busy), 0);
        check("reset_done", int'(bus_a.done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // LSL of 11110000 by 1, 3, 6
        issue2(0, 8'hF0, 1);
        issue2(0, 8'hF0, 3);
        issue2(0, 8'hF0, 6);
        // ASR by 3, LSR past WIDTH
        issue2(2, 8'h96, 3);
        issue2(1, 8'h96, 9);
        // ROL modulo WIDTH, and a ROL that takes two STEP=4 chunks
        issue2(3, 8'hA5, 11);
        issue2(3, 8'hA5, 5);
        // Past-WIDTH cases for LSL and ASR, and an exact-WIDTH LSL
        issue2(0, 8'h81, 12);
        issue2(2, 8'h80, 15);
        issue2(0, 8'h01, 8);

        // Shift by zero: done right away, busy never raised
        issue2(1, 8'h5A, 0);
        check("zero_busy", int'(bus_a.busy), 0);
        check("zero_done", int'(bus_a.done), 1);

        // start while busy must be ignored
        issue2(0, 8'h3C, 6);
        @(negedge clk);
        check("busy_during_op", int'(bus_a.busy), 1);
        bus_a.start = 1'b1;
        bus_a.mode  = 2'b11;
        bus_a.in_a  = 8'hFF;
        bus_a.shift = 4'd1;
        @(negedge clk);
        bus_a.start = 1'b0;

        for (int i = 0; i < 40; i++) issue_rand2();

        // Asynchronous reset in the middle of a long operation
        issue2(0, 8'hC3, 15);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_a_out", int'(bus_a.out), 0);
        check("rst_a_cout", int'(bus_a.cout), 0);
        check("rst_a_busy", int'(bus_a.busy), 0);
        check("rst_a_done", int'(bus_a.done), 0);
        check("rst_b_out", int'(bus_b.out), 0);
        check("rst_b_busy", int'(bus_b.busy), 0);
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) issue_rand2();

        b2b_a(25);

        g = 0;
        while ((qa.size() != 0 || qb.size() != 0) && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("drain_a", qa.size(), 0);
        check("drain_b", qb.size(), 0);

        // Result holds through IDLE
        repeat (4) @(negedge clk);
        check("idle_hold_out", int'(bus_a.out), last_a_out);
        check("idle_busy", int'(bus_a.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
